// File: rtl/lrshift_rr_arbiter.sv
// lrshift_rr_arbiter: round-robin arbiter sharing one left/right shifter with a registered response buffer.
// Define LRSHIFT_RR_ARBITER_PRIO0_EN to give requester 0 strict priority over the rotating requesters.
module lrshift_rr_arbiter #(
    parameter int width = 8,
    parameter int NUM_REQ = 4,
    localparam int SW = $clog2(width),
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*width-1:0] req_bits,
    input  logic [NUM_REQ*SW-1:0]   req_shift,
    input  logic [NUM_REQ-1:0]      req_dir,
    output logic [width-1:0]        sh_iBits,
    output logic [SW-1:0]           sh_shift,
    output logic                    sh_dir,
    input  logic [width-1:0]        sh_oBits,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [width-1:0]        resp_bits,
    output logic [IW-1:0]           resp_id
);
    localparam int IW1 = IW + 1;
`ifdef LRSHIFT_RR_ARBITER_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif
    logic [IW-1:0] rr_ptr, gnt, sel, ptr_next;
    logic [IW:0] idx;
    logic found, grant, out_free, adv;
    assign out_free = !resp_valid || resp_ready;
    always_comb begin
        gnt = rr_ptr;
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + IW1'(k);
            idx = (idx >= IW1'(NUM_REQ)) ? idx - IW1'(NUM_REQ) : idx;
            if (!found && (!PRIO0 || idx != '0) && req_valid[idx[IW-1:0]]) begin
                gnt = idx[IW-1:0];
                found = 1'b1;
            end
        end
        if (PRIO0 && req_valid[0]) begin
            gnt = '0;
            found = 1'b1;
        end
    end
    // rst gates the grant so req_ready is low for the whole reset, not just after the first edge
    assign grant     = found && out_free && !rst;
    assign req_ready = grant ? NUM_REQ'(1) << gnt : '0;
    assign sel       = grant ? gnt : rr_ptr;
    assign sh_iBits  = req_bits[sel*width +: width];
    assign sh_shift  = req_shift[sel*SW +: SW];
    assign sh_dir    = req_dir[sel];
    assign ptr_next  = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1);
    assign adv       = !PRIO0 || gnt != '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_bits  <= '0;
            resp_id    <= '0;
            rr_ptr     <= '0;
        end else if (grant) begin
            resp_valid <= 1'b1;
            resp_bits  <= sh_oBits;
            resp_id    <= gnt;
            if (adv) rr_ptr <= ptr_next;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lrshift_rr_arbiter.sv
// tb_lrshift_rr_arbiter: randomized and directed checks of lrshift_rr_arbiter against a behavioural model.
module tb_lrshift_rr_arbiter;
    localparam int W = 8, N = 4, SW = 3, IW = 2;
`ifdef LRSHIFT_RR_ARBITER_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req_valid = '0, req_ready, req_dir = '0;
    logic [N*W-1:0] req_bits = '0;
    logic [N*SW-1:0] req_shift = '0;
    logic [W-1:0] sh_iBits, sh_oBits, resp_bits;
    logic [SW-1:0] sh_shift;
    logic sh_dir, resp_valid, resp_ready = 1'b1;
    logic [IW-1:0] resp_id;
    // three-requester instance for the non-power-of-2 wrap
    logic [2:0] v3 = '0, rdy3;
    logic [3*W-1:0] bits3 = 24'h030201;
    logic [3*SW-1:0] shift3 = '0;
    logic [2:0] dir3 = '0;
    logic [W-1:0] shi3, sho3, rb3;
    logic [SW-1:0] shs3;
    logic shd3, rv3;
    logic rr3 = 1'b1;
    logic [1:0] rid3;
    int n_checks = 0, n_fail = 0;
    int m_ptr = 0, m_id = 0;
    bit m_valid = 0;
    logic [W-1:0] m_bits = '0;

    always #5 clk = ~clk;
    assign sh_oBits = sh_dir ? sh_iBits >> sh_shift : sh_iBits << sh_shift;
    assign sho3 = shd3 ? shi3 >> shs3 : shi3 << shs3;

    lrshift_rr_arbiter #(.width(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_bits(req_bits), .req_shift(req_shift), .req_dir(req_dir),
        .sh_iBits(sh_iBits), .sh_shift(sh_shift), .sh_dir(sh_dir), .sh_oBits(sh_oBits),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bits(resp_bits), .resp_id(resp_id));

    lrshift_rr_arbiter #(.width(W), .NUM_REQ(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
        .req_bits(bits3), .req_shift(shift3), .req_dir(dir3),
        .sh_iBits(shi3), .sh_shift(shs3), .sh_dir(shd3), .sh_oBits(sho3),
        .resp_valid(rv3), .resp_ready(rr3), .resp_bits(rb3), .resp_id(rid3));

    function automatic logic [W-1:0] ref_shift(logic [W-1:0] b, int s, bit d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            if (d) r[i] = (i + s < W) ? b[i+s] : 1'b0;
            else   r[i] = (i >= s) ? b[i-s] : 1'b0;
        return r;
    endfunction

    function automatic int exp_gnt();
        if (rst || (m_valid && !resp_ready)) return -1;
        if (PRIO && req_valid[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (!(PRIO && i == 0) && req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int g);
        return (g < 0) ? '0 : N'(1) << g;
    endfunction

    task automatic set_req(int i, logic [W-1:0] b, int s, bit d);
        req_bits[i*W +: W] = b;
        req_shift[i*SW +: SW] = SW'(s);
        req_dir[i] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_bits = '0; m_id = 0;
    endtask

    task automatic tick(output int g);
        g = exp_gnt();
        if (g >= 0) begin
            m_valid = 1;
            m_id = g;
            m_bits = ref_shift(req_bits[g*W +: W], int'(req_shift[g*SW +: SW]), req_dir[g]);
            if (!(PRIO && g == 0)) m_ptr = (g + 1) % N;
        end else if (resp_ready) m_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if ({resp_valid, resp_bits, resp_id, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_init got v=%b b=%h id=%0d rdy=%b exp all zero", resp_valid, resp_bits, resp_id, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        model_reset();
    endtask

    task automatic test_wrap3();
        logic [2:0] e;
        int g;
        v3 = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            e = PRIO ? 3'b001 : 3'(1 << (k % 3));
            n_checks++;
            if (rdy3 !== e) begin
                n_fail++;
                $display("FAIL wrap3_ready[%0d] got %b exp %b", k, rdy3, e);
            end
            tick(g);
            n_checks++;
            if (rid3 !== 2'(PRIO ? 0 : k % 3)) begin
                n_fail++;
                $display("FAIL wrap3_id[%0d] got %0d exp %0d", k, rid3, PRIO ? 0 : k % 3);
            end
        end
        v3 = '0;
    endtask

    task automatic test_single();
        int g;
        set_req(1, 8'hB3, 3, 1'b0);
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_ready got %b exp 0010", req_ready);
        end
        tick(g);
        n_checks++;
        if ({resp_valid, resp_bits, resp_id} !== {1'b1, 8'h98, 2'd1}) begin
            n_fail++;
            $display("FAIL single_left got v=%b b=%h id=%0d exp v=1 b=98 id=1", resp_valid, resp_bits, resp_id);
        end
        req_dir[1] = 1'b1;
        tick(g);
        n_checks++;
        if ({resp_valid, resp_bits, resp_id} !== {1'b1, 8'h16, 2'd1}) begin
            n_fail++;
            $display("FAIL single_right got v=%b b=%h id=%0d exp v=1 b=16 id=1", resp_valid, resp_bits, resp_id);
        end
        req_valid = '0;
        tick(g);
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain got v=%b exp 0", resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int g, e;
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom));
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = PRIO ? 0 : k % N;
            #1;
            n_checks++;
            if (req_ready !== onehot(e)) begin
                n_fail++;
                $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, onehot(e));
            end
            tick(g);
            n_checks++;
            if ({resp_valid, resp_id, resp_bits} !== {1'b1, 2'(e), m_bits}) begin
                n_fail++;
                $display("FAIL rr_resp[%0d] got v=%b id=%0d b=%h exp v=1 id=%0d b=%h", k, resp_valid, resp_id, resp_bits, e, m_bits);
            end
        end
    endtask

    task automatic test_backpressure();
        int g;
        logic [W-1:0] hb;
        logic [IW-1:0] hid;
        hb = resp_bits;
        hid = resp_id;
        set_req(2, 8'hC5, 2, 1'b1);
        req_valid = 4'b0100;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_ready[%0d] got %b exp 0000", k, req_ready);
            end
            tick(g);
            n_checks++;
            if ({resp_valid, resp_bits, resp_id} !== {1'b1, hb, hid}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b b=%h id=%0d exp v=1 b=%h id=%0d", k, resp_valid, resp_bits, resp_id, hb, hid);
            end
        end
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_release_ready got %b exp 0100", req_ready);
        end
        tick(g);
        n_checks++;
        if ({resp_valid, resp_bits, resp_id} !== {1'b1, 8'h31, 2'd2}) begin
            n_fail++;
            $display("FAIL bp_refill got v=%b b=%h id=%0d exp v=1 b=31 id=2", resp_valid, resp_bits, resp_id);
        end
        req_valid = '0;
    endtask

    task automatic test_boundary();
        int g;
        set_req(3, 8'hFF, 7, 1'b0);
        req_valid = 4'b1000;
        tick(g);
        n_checks++;
        if ({resp_bits, resp_id} !== {8'h80, 2'd3}) begin
            n_fail++;
            $display("FAIL bound_left7 got b=%h id=%0d exp b=80 id=3", resp_bits, resp_id);
        end
        set_req(0, 8'h5A, 0, 1'b1);
        req_valid = 4'b0001;
        tick(g);
        n_checks++;
        if ({resp_bits, resp_id} !== {8'h5A, 2'd0}) begin
            n_fail++;
            $display("FAIL bound_right0 got b=%h id=%0d exp b=5a id=0", resp_bits, resp_id);
        end
        req_valid = '0;
        tick(g);
    endtask

    task automatic test_prio();
        int g;
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (req_ready !== onehot(exp_gnt()) || (PRIO && req_ready !== 4'b0001)) begin
                n_fail++;
                $display("FAIL prio_ready[%0d] got %b exp %b", k, req_ready, onehot(exp_gnt()));
            end
            tick(g);
        end
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL prio_drop got %b exp 0100", req_ready);
        end
        tick(g);
        req_valid = '0;
        tick(g);
    endtask

    task automatic test_reset_mid();
        int g;
        set_req(1, 8'h0F, 1, 1'b0);
        req_valid = 4'b0010;
        resp_ready = 1'b0;
        tick(g);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({resp_valid, resp_bits, resp_id, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got v=%b b=%h id=%0d rdy=%b exp all zero", resp_valid, resp_bits, resp_id, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({resp_valid, req_ready} !== {1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL reset_release got v=%b rdy=%b exp v=0 rdy=0010", resp_valid, req_ready);
        end
        resp_ready = 1'b1;
        req_valid = '0;
        tick(g);
    endtask

    task automatic test_random();
        int g = -1;
        for (int c = 0; c < 400; c++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (!(req_valid[i] && g != i)) begin
                    req_valid[i] = 1'($urandom);
                    set_req(i, W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom));
                end
            #1;
            n_checks++;
            if (req_ready !== onehot(exp_gnt())) begin
                n_fail++;
                $display("FAIL rand_ready[%0d] got %b exp %b", c, req_ready, onehot(exp_gnt()));
            end
            tick(g);
            n_checks++;
            if (resp_valid !== m_valid || (m_valid && {resp_bits, resp_id} !== {m_bits, 2'(m_id)})) begin
                n_fail++;
                $display("FAIL rand_resp[%0d] got v=%b b=%h id=%0d exp v=%b b=%h id=%0d", c, resp_valid, resp_bits, resp_id, m_valid, m_bits, m_id);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_wrap3();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_boundary();
        test_prio();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lrshift_rr_arbiter.md
Name: lrshift_rr_arbiter

Overview:
- Shares one combinational left-right bits shifter (iBits/shift/dir -> oBits) among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the shifter from the granted request and captures the result into a one-entry registered response buffer with a valid/ready output handshake.
- Sits between shift-issuing clients and the shared shifter instance.

Parameters:
- width, 8, bit width of data; power of 2, >= 2.
- NUM_REQ, 4, number of requesters; 2..16.
- Derived SW = clog2(width): shift-amount width. Derived IW = clog2(NUM_REQ): requester-id width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_bits  in  NUM_REQ*width  packed operands; requester i at [i*width +: width].
- req_shift  in  NUM_REQ*SW  packed shift amounts.
- req_dir  in  NUM_REQ  direction per requester; 0 = ShiftDir_Left, 1 = ShiftDir_Right.
- sh_iBits  out  width  to shifter iBits.
- sh_shift  out  SW  to shifter shift.
- sh_dir  out  1  to shifter dir.
- sh_oBits  in  width  from shifter oBits; same-cycle combinational.
- resp_valid  out  1  response buffer holds a result.
- resp_ready  in  1  consumer accepts the response.
- resp_bits  out  width  shifted result.
- resp_id  out  IW  index of the requester that produced resp_bits.

Behaviour:
- Reset (async assert, sync deassert by design): resp_valid=0, resp_bits=0, resp_id=0, rr_ptr=0. req_ready=0 while rst=1.
- out_free = !resp_valid || resp_ready. Response buffer states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- Grant: when out_free and any req_valid, gnt = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
- req_ready[gnt] = 1; all other bits 0. req_ready is combinational from req_valid, rr_ptr and out_free. Requesters must not make req_valid depend on req_ready.
- Shifter drive:
  - sh_* = granted requester's bits/shift/dir when a grant exists.
  - Otherwise sh_* = requester rr_ptr's fields, so there is no X-propagation.
- Accept (req_valid[gnt] && req_ready[gnt]) at edge:
  - resp_bits <= sh_oBits; resp_id <= gnt; resp_valid <= 1.
  - rr_ptr <= (gnt+1) mod NUM_REQ. For non-power-of-2 NUM_REQ, the wrap is explicit.
- Latency: request accepted in cycle N -> resp_valid=1 in cycle N+1.
- Throughput: 1 result/cycle while resp_ready=1.
- FULL && !resp_ready: no grant; resp_bits/resp_id held stable; rr_ptr unchanged.
- FULL && resp_ready && no request: resp_valid <= 0 (FULL -> EMPTY).
- FULL && resp_ready && request: drain and refill in the same cycle; resp_valid stays 1 with the new data.
- rr_ptr advances only on accept, never on idle or stall cycles.
- A requester holding req_valid without ready must keep its fields stable. The arbiter does not check this.
- Shift semantics are the shifter's. Logical shifts; vacated bits are 0; shift=0 passes data through.
- rst mid-transfer: in-flight response is discarded; no partial state survives.

Optional Feature:
- Macro: LRSHIFT_RR_ARBITER_PRIO0_EN.
- Defined: requester 0 has strict priority. If req_valid[0] && out_free, gnt=0 regardless of rr_ptr, and rr_ptr is not updated by a requester-0 grant. Other requesters rotate round-robin among themselves as specified, with the scan skipping index 0.
- Undefined: pure round-robin over all NUM_REQ requesters as above.

Test Plan:
- Reset with width=8, NUM_REQ=4: assert rst mid-cycle -> resp_valid=0, resp_bits=0, resp_id=0, req_ready=0 immediately, independent of clk.
- Single request, r1 bits=8'hB3, shift=3, dir=Left, resp_ready=1:
  - req_ready=4'b0010 same cycle.
  - Next cycle resp_valid=1, resp_bits=8'h98, resp_id=1.
  - Same operands with dir=Right -> 8'h16.
- All four valid continuously, resp_ready=1: grant order 0,1,2,3,0,... and resp_id sequence matches, one result per cycle.
- Backpressure: response FULL, resp_ready=0 for 3 cycles with r2 valid:
  - req_ready=0 throughout; resp_bits/resp_id stable.
  - On resp_ready=1, r2 is granted the same cycle; a new result appears next cycle with no bubble.
- Boundary: shift=7 Left on 8'hFF -> 8'h80; shift=0 Right on 8'h5A -> 8'h5A. NUM_REQ=3 wrap: rr_ptr sequence 0,1,2,0.
- With LRSHIFT_RR_ARBITER_PRIO0_EN, r0 and r2 valid continuously -> r0 is granted every cycle and r2 is starved. Drop r0 -> r2 is granted next.
